// File: rtl/cabac_bin_sched_pkg.sv
// rtl/cabac_bin_sched_pkg.sv - shared encodings and constants for the CABAC bin scheduler
package cabac_bin_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2,
    ST_END  = 2'd3
  } state_e;

  localparam logic       REQ_BYPASS = 1'b0;
  localparam logic       REQ_TERM   = 1'b1;
  localparam logic [8:0] INIT_RANGE = 9'd510;
  localparam logic [4:0] INIT_BITS  = 5'd9;

endpackage

// File: rtl/cabac_terminate_decode_bin.sv
// rtl/cabac_terminate_decode_bin.sv - combinational terminate-bin arithmetic with one-step renormalisation
module cabac_terminate_decode_bin (
  input  logic [8:0] range_i,
  input  logic [8:0] offset_i,
  input  logic       bit_i,
  output logic       bin_o,
  output logic [8:0] range_o,
  output logic [8:0] offset_o,
  output logic       len_o
);

  logic [8:0] r2;
  assign r2 = range_i - 9'd2;

  always_comb begin
    bin_o    = 1'b0;
    range_o  = r2;
    offset_o = offset_i;
    len_o    = 1'b0;
    if (offset_i >= r2) begin
      bin_o = 1'b1;
    end else if (r2[8:7] == 2'b01) begin
      // range fell below 256: one renormalisation step pulls in a bitstream bit
      range_o  = {r2[7:0], 1'b0};
      offset_o = {offset_i[7:0], bit_i};
      len_o    = 1'b1;
    end
  end

endmodule

// File: rtl/cabac_bin_sched.sv
// rtl/cabac_bin_sched.sv - CABAC bypass/terminate bin scheduler with byte-fed bit buffer
// Optional CABAC_BIN_COUNT_EN adds a 32-bit count of delivered bins on o_bin_count.
module cabac_bin_sched
  import cabac_bin_sched_pkg::*;
#(
  parameter int unsigned BUF_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start_init,
  input  logic [7:0]  i_byte,
  input  logic        i_byte_valid,
  output logic        o_byte_ready,
  input  logic        i_req,
  input  logic        i_req_type,
  output logic        o_req_ready,
  output logic        o_bin_valid,
  output logic        o_bin,
  output logic [8:0]  o_ivlCurrRange,
  output logic [8:0]  o_ivlOffset,
  output logic        o_done
`ifdef CABAC_BIN_COUNT_EN
  ,
  output logic [31:0] o_bin_count
`endif
);

  state_e           state_q, state_d;
  logic [BUF_W-1:0] buf_q, buf_d, buf_pop;
  logic [4:0]       cnt_q, cnt_d, cnt_pop;
  logic [8:0]       range_q, range_d, offset_q, offset_d;
  logic             bin_valid_q, bin_valid_d, bin_q, bin_d;
  logic             req_acc, byte_acc, init_load;
  logic [3:0]       pop;
  logic [8:0]       byp_t;
  logic             next_bit;
  logic             term_bin, term_len;
  logic [8:0]       term_range, term_offset;

  assign next_bit  = buf_q[BUF_W-1];
  assign req_acc   = i_req & o_req_ready & ~i_start_init;
  assign byte_acc  = i_byte_valid & o_byte_ready & ~i_start_init;
  assign init_load = (state_q == ST_INIT) && (cnt_q >= INIT_BITS) && !i_start_init;
  assign byp_t     = {offset_q[7:0], next_bit};

  cabac_terminate_decode_bin u_term (
    .range_i  (range_q),
    .offset_i (offset_q),
    .bit_i    (next_bit),
    .bin_o    (term_bin),
    .range_o  (term_range),
    .offset_o (term_offset),
    .len_o    (term_len)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (i_start_init) begin
      state_d = ST_INIT;
    end else begin
      case (state_q)
        ST_INIT: if (cnt_q >= INIT_BITS) state_d = ST_RUN;
        ST_RUN:  if (req_acc && (i_req_type == REQ_TERM) && term_bin) state_d = ST_END;
        default: state_d = state_q;
      endcase
    end
  end

  // ready flags look only at registered state and count, never at the requests
  always_comb begin
    o_byte_ready = ((state_q == ST_INIT) || (state_q == ST_RUN)) && (cnt_q <= 5'd8);
    o_req_ready  = (state_q == ST_RUN) && (cnt_q != 5'd0);
    o_done       = (state_q == ST_END);
  end

  always_comb begin
    pop         = 4'd0;
    range_d     = range_q;
    offset_d    = offset_q;
    bin_valid_d = 1'b0;
    bin_d       = bin_q;
    if (init_load) begin
      pop      = 4'd9;
      range_d  = INIT_RANGE;
      offset_d = buf_q[BUF_W-1 -: 9];
    end else if (req_acc) begin
      bin_valid_d = 1'b1;
      if (i_req_type == REQ_BYPASS) begin
        pop = 4'd1;
        if (byp_t >= range_q) begin
          bin_d    = 1'b1;
          offset_d = byp_t - range_q;
        end else begin
          bin_d    = 1'b0;
          offset_d = byp_t;
        end
      end else begin
        pop      = {3'b000, term_len};
        bin_d    = term_bin;
        range_d  = term_range;
        offset_d = term_offset;
      end
    end

    // pop first, then append the byte right behind the surviving bits
    cnt_pop = cnt_q - {1'b0, pop};
    buf_pop = buf_q << pop;
    buf_d   = buf_pop;
    cnt_d   = cnt_pop;
    if (byte_acc) begin
      buf_d = buf_pop | ({i_byte, {(BUF_W-8){1'b0}}} >> cnt_pop);
      cnt_d = cnt_pop + 5'd8;
    end
    if (i_start_init) begin
      buf_d       = '0;
      cnt_d       = '0;
      bin_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q       <= '0;
      cnt_q       <= '0;
      range_q     <= '0;
      offset_q    <= '0;
      bin_valid_q <= 1'b0;
      bin_q       <= 1'b0;
    end else begin
      buf_q       <= buf_d;
      cnt_q       <= cnt_d;
      range_q     <= range_d;
      offset_q    <= offset_d;
      bin_valid_q <= bin_valid_d;
      bin_q       <= bin_d;
    end
  end

  assign o_bin_valid    = bin_valid_q;
  assign o_bin          = bin_q;
  assign o_ivlCurrRange = range_q;
  assign o_ivlOffset    = offset_q;

`ifdef CABAC_BIN_COUNT_EN
  logic [31:0] bin_count_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            bin_count_q <= '0;
    else if (i_start_init) bin_count_q <= '0;
    else if (bin_valid_d)  bin_count_q <= bin_count_q + 32'd1;
  end
  assign o_bin_count = bin_count_q;
`endif

endmodule

// File: tb/tb_cabac_bin_sched.sv
// tb/tb_cabac_bin_sched.sv - directed bench for cabac_bin_sched with a bit-queue reference model
module tb_cabac_bin_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_start_init = 1'b0;
  logic [7:0]  i_byte = 8'h00;
  logic        i_byte_valid = 1'b0;
  logic        i_req = 1'b0;
  logic        i_req_type = 1'b0;
  logic        o_byte_ready, o_req_ready, o_bin_valid, o_bin, o_done;
  logic [8:0]  o_ivlCurrRange, o_ivlOffset;
`ifdef CABAC_BIN_COUNT_EN
  logic [31:0] o_bin_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cabac_bin_sched #(.BUF_W(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_start_init   (i_start_init),
    .i_byte         (i_byte),
    .i_byte_valid   (i_byte_valid),
    .o_byte_ready   (o_byte_ready),
    .i_req          (i_req),
    .i_req_type     (i_req_type),
    .o_req_ready    (o_req_ready),
    .o_bin_valid    (o_bin_valid),
    .o_bin          (o_bin),
    .o_ivlCurrRange (o_ivlCurrRange),
    .o_ivlOffset    (o_ivlOffset),
    .o_done         (o_done)
`ifdef CABAC_BIN_COUNT_EN
    ,
    .o_bin_count    (o_bin_count)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: bitstream kept as a queue of bits, arithmetic on plain ints
  localparam int M_IDLE = 0, M_INIT = 1, M_RUN = 2, M_END = 3;
  int          m_st = M_IDLE;
  bit          m_bits[$];
  int          m_range = 0, m_offset = 0;
  bit          m_bv = 1'b0, m_bin = 1'b0;
  logic [31:0] m_cnt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st = M_IDLE; m_bits.delete(); m_range = 0; m_offset = 0;
      m_bv = 1'b0; m_bin = 1'b0; m_cnt = 0;
    end else begin
      bit rdy_req, rdy_byte;
      int t, r2;
      rdy_req  = (m_st == M_RUN) && (m_bits.size() >= 1);
      rdy_byte = (m_st == M_INIT || m_st == M_RUN) && (m_bits.size() <= 8);
      m_bv = 1'b0;
      if (i_start_init) begin
        m_st = M_INIT; m_bits.delete(); m_cnt = 0;
      end else begin
        if (m_st == M_INIT && m_bits.size() >= 9) begin
          m_range = 510; m_offset = 0;
          repeat (9) m_offset = m_offset * 2 + int'(m_bits.pop_front());
          m_st = M_RUN;
        end else if (m_st == M_RUN && i_req && rdy_req) begin
          m_bv = 1'b1; m_cnt = m_cnt + 1;
          if (i_req_type == 1'b0) begin
            t = (m_offset % 256) * 2 + int'(m_bits.pop_front());
            if (t >= m_range) begin m_bin = 1'b1; m_offset = t - m_range; end
            else begin m_bin = 1'b0; m_offset = t; end
          end else begin
            r2 = m_range - 2;
            if (m_offset >= r2) begin
              m_bin = 1'b1; m_range = r2; m_st = M_END;
            end else begin
              m_bin = 1'b0;
              if (r2 >= 128 && r2 < 256) begin
                m_range = r2 * 2;
                m_offset = (m_offset % 256) * 2 + int'(m_bits.pop_front());
              end else begin
                m_range = r2;
              end
            end
          end
        end
        if (i_byte_valid && rdy_byte)
          for (int i = 7; i >= 0; i--) m_bits.push_back(i_byte[i]);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      chk("m_req_ready",  o_req_ready,  (m_st == M_RUN) && (m_bits.size() >= 1));
      chk("m_byte_ready", o_byte_ready, (m_st == M_INIT || m_st == M_RUN) && (m_bits.size() <= 8));
      chk("m_done",       o_done,       m_st == M_END);
      chk("m_bin_valid",  o_bin_valid,  m_bv);
      if (m_bv) chk("m_bin", o_bin, m_bin);
      chk("m_range",      o_ivlCurrRange, m_range);
      chk("m_offset",     o_ivlOffset,    m_offset);
`ifdef CABAC_BIN_COUNT_EN
      chk("m_bin_count",  o_bin_count,    m_cnt);
`endif
    end
  end

  task automatic wait_run();
    int k = 0;
    while (!o_req_ready && k < 40) begin @(negedge clk); k++; end
    chk("req_ready_timeout", o_req_ready, 1);
  endtask

  task automatic push_byte(input logic [7:0] b);
    int k = 0;
    while (!o_byte_ready && k < 40) begin @(negedge clk); k++; end
    chk("byte_ready_timeout", o_byte_ready, 1);
    i_byte = b; i_byte_valid = 1'b1;
    @(negedge clk);
    i_byte_valid = 1'b0;
  endtask

  task automatic do_init(input logic [7:0] b0, input logic [7:0] b1);
    i_start_init = 1'b1;
    @(negedge clk);
    i_start_init = 1'b0;
    push_byte(b0);
    push_byte(b1);
    wait_run();
  endtask

  task automatic bin_req(input logic typ, input logic exp_bin, input int exp_rng,
                         input int exp_off, input string name);
    wait_run();
    i_req = 1'b1; i_req_type = typ;
    @(negedge clk);
    i_req = 1'b0;
    chk({name, "_valid"},  o_bin_valid,    1);
    chk({name, "_bin"},    o_bin,          exp_bin);
    chk({name, "_range"},  o_ivlCurrRange, exp_rng);
    chk({name, "_offset"}, o_ivlOffset,    exp_off);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_byte_ready", o_byte_ready, 0);
    chk("rst_req_ready",  o_req_ready,  0);
    chk("rst_bin_valid",  o_bin_valid,  0);
    chk("rst_bin",        o_bin,        0);
    chk("rst_range",      o_ivlCurrRange, 0);
    chk("rst_offset",     o_ivlOffset,  0);
    chk("rst_done",       o_done,       0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_byte_ready", o_byte_ready, 0);

    do_init(8'h00, 8'h00);
    chk("init_range",  o_ivlCurrRange, 510);
    chk("init_offset", o_ivlOffset,    0);
    bin_req(1'b1, 1'b0, 508, 0, "term0");

    do_init(8'hFF, 8'h80);
    chk("init1_offset", o_ivlOffset, 511);
    bin_req(1'b1, 1'b1, 508, 511, "term1");
    chk("end_done",      o_done,      1);
    chk("end_req_ready", o_req_ready, 0);

    do_init(8'hFF, 8'h00);
    bin_req(1'b0, 1'b0, 510, 508, "byp_a0");
    bin_req(1'b0, 1'b0, 510, 504, "byp_a1");
    do_init(8'h7F, 8'hC0);
    chk("init2_offset", o_ivlOffset, 255);
    bin_req(1'b0, 1'b1, 510, 1, "byp_b0");
    bin_req(1'b0, 1'b0, 510, 2, "byp_b1");

    // 128 back-to-back terminates; 7 zero bits are left after init
    do_init(8'h00, 8'h00);
    i_req = 1'b1; i_req_type = 1'b1;
    repeat (127) @(negedge clk);
    chk("renorm127_range", o_ivlCurrRange, 256);
    chk("renorm127_valid", o_bin_valid, 1);
    @(negedge clk);
    chk("renorm128_range",  o_ivlCurrRange, 508);
    chk("renorm128_offset", o_ivlOffset, 0);

    // drain the remaining 6 bits with bypass bins, then starve
    i_req_type = 1'b0;
    repeat (6) @(negedge clk);
    chk("drain_offset", o_ivlOffset, 0);
    repeat (3) @(negedge clk);
    chk("stall_req_ready", o_req_ready, 0);
    chk("stall_no_valid",  o_bin_valid, 0);
    i_byte = 8'hA5; i_byte_valid = 1'b1;
    @(negedge clk);
    i_byte_valid = 1'b0;
    chk("refill_req_ready", o_req_ready, 1);
    chk("refill_no_valid",  o_bin_valid, 0);
    @(negedge clk);
    i_req = 1'b0;
    chk("refill_valid",  o_bin_valid, 1);
    chk("refill_bin",    o_bin,       0);
    chk("refill_offset", o_ivlOffset, 1);

    // abort: start, accepted request and offered byte in the same cycle
    i_start_init = 1'b1; i_req = 1'b1; i_req_type = 1'b0;
    i_byte = 8'h3C; i_byte_valid = 1'b1;
    @(negedge clk);
    i_start_init = 1'b0; i_req = 1'b0; i_byte_valid = 1'b0;
    chk("abort_no_valid",   o_bin_valid,  0);
    chk("abort_req_ready",  o_req_ready,  0);
    chk("abort_byte_ready", o_byte_ready, 1);
`ifdef CABAC_BIN_COUNT_EN
    chk("abort_bin_count",  o_bin_count,  0);
`endif
    push_byte(8'h00);
    @(negedge clk);
    chk("abort_one_byte_not_run", o_req_ready, 0);
    push_byte(8'h00);
    wait_run();
    chk("abort_reinit_range",  o_ivlCurrRange, 510);
    chk("abort_reinit_offset", o_ivlOffset,    0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
